// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: access kind and response status.
// The status encoding matches the AXI4-Lite xRESP field bit for bit.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_READ  = 2'b10,
    RGGEN_WRITE = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// Simple valid/ready register bus between a protocol bridge (master)
// and the register block (slave).
interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);

  logic                       valid;
  rggen_access                access;
  logic [ADDRESS_WIDTH-1:0]   address;
  logic [BUS_WIDTH-1:0]       write_data;
  logic [BUS_WIDTH/8-1:0]     strobe;
  logic                       ready;
  rggen_status                status;
  logic [BUS_WIDTH-1:0]       read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );

endinterface

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave to rggen register bus bridge: one transaction in flight,
// round-robin arbitration between a complete write (AW+W) and a read (AR).
module rggen_axi4lite_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
  input  logic [2:0]               i_awprot,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [BUS_WIDTH-1:0]     i_wdata,
  input  logic [BUS_WIDTH/8-1:0]   i_wstrb,
  output logic                     o_bvalid,
  input  logic                     i_bready,
  output logic [1:0]               o_bresp,
  input  logic                     i_arvalid,
  output logic                     o_arready,
  input  logic [ADDRESS_WIDTH-1:0] i_araddr,
  input  logic [2:0]               i_arprot,
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [BUS_WIDTH-1:0]     o_rdata,
  output logic [1:0]               o_rresp,
  rggen_bus_if.master              bus_if
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WRITE_RESPONSE,
    READ_RESPONSE
  } state_e;

  state_e                   state;
  state_e                   state_next;
  logic                     last_grant_read;
  logic                     grant_write;
  logic                     grant_read;
  logic                     write_pending;
  logic                     read_pending;
  logic                     in_idle;

  rggen_access              access_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [BUS_WIDTH/8-1:0]   strobe_q;
  rggen_status              status_q;
  logic [BUS_WIDTH-1:0]     read_data_q;

  // Protection attributes carry no meaning for the register bus.
  logic                     unused_prot;
  assign unused_prot = ^{i_awprot, i_arprot};

  // Grants are suppressed while reset is asserted so nothing is acknowledged
  // on the AXI side that the reset would then discard.
  assign in_idle       = (state == IDLE) && !i_rst;
  assign write_pending = i_awvalid && i_wvalid;
  assign read_pending  = i_arvalid;
  assign grant_write   = in_idle && write_pending && (!read_pending || last_grant_read);
  assign grant_read    = in_idle && read_pending && (!write_pending || !last_grant_read);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first; a branch that
  // forgets an assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_write || grant_read) begin
          state_next = REQUEST;
        end
      end
      REQUEST: begin
        if (bus_if.ready) begin
          state_next = (access_q == RGGEN_WRITE) ? WRITE_RESPONSE : READ_RESPONSE;
        end
      end
      WRITE_RESPONSE: begin
        if (i_bready) begin
          state_next = IDLE;
        end
      end
      READ_RESPONSE: begin
        if (i_rready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_awready    = grant_write;
    o_wready     = grant_write;
    o_arready    = grant_read;
    bus_if.valid = (state == REQUEST);
    o_bvalid     = (state == WRITE_RESPONSE);
    o_rvalid     = (state == READ_RESPONSE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_read <= 1'b1;
    end else if (grant_write || grant_read) begin
      last_grant_read <= grant_read;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      access_q     <= rggen_access'(2'b00);
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      status_q     <= RGGEN_OKAY;
      read_data_q  <= '0;
    end else begin
      if (grant_write) begin
        access_q     <= RGGEN_WRITE;
        address_q    <= i_awaddr;
        write_data_q <= i_wdata;
        strobe_q     <= i_wstrb;
      end else if (grant_read) begin
        access_q     <= RGGEN_READ;
        address_q    <= i_araddr;
        write_data_q <= '0;
        strobe_q     <= '1;
      end
      if ((state == REQUEST) && bus_if.ready) begin
        status_q <= bus_if.status;
        if (access_q == RGGEN_READ) begin
          read_data_q <= bus_if.read_data;
        end
      end
    end
  end

  assign bus_if.access     = access_q;
  assign bus_if.address    = address_q;
  assign bus_if.write_data = write_data_q;
  assign bus_if.strobe     = strobe_q;

  // B and R share the single captured status; only one is ever presented.
  assign o_bresp = status_q;
  assign o_rresp = status_q;
  assign o_rdata = read_data_q;

endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Directed vector bench for rggen_axi4lite_bridge: a cycle table for plain
// transactions plus sequences for arbitration, partial writes and reset.
module tb_rggen_axi4lite_bridge;
  import rggen_rtl_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          awvalid, wvalid, arvalid, bready, rready;
  logic          awready, wready, arready, bvalid, rvalid;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_if ();

  rggen_axi4lite_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_awvalid (awvalid),
    .o_awready (awready),
    .i_awaddr  (awaddr),
    .i_awprot  (3'b000),
    .i_wvalid  (wvalid),
    .o_wready  (wready),
    .i_wdata   (wdata),
    .i_wstrb   (wstrb),
    .o_bvalid  (bvalid),
    .i_bready  (bready),
    .o_bresp   (bresp),
    .i_arvalid (arvalid),
    .o_arready (arready),
    .i_araddr  (araddr),
    .i_arprot  (3'b000),
    .o_rvalid  (rvalid),
    .i_rready  (rready),
    .o_rdata   (rdata),
    .o_rresp   (rresp),
    .bus_if    (bus_if)
  );

  // Control outputs packed as {awready, wready, arready, bus valid, bvalid, rvalid}.
  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_WGNT = 6'b110000;
  localparam logic [5:0] C_RGNT = 6'b001000;
  localparam logic [5:0] C_REQ  = 6'b000100;
  localparam logic [5:0] C_B    = 6'b000010;
  localparam logic [5:0] C_R    = 6'b000001;

  // Inputs packed as {awvalid, wvalid, arvalid, bready, rready, bus ready}.
  typedef struct {
    string       name;
    logic [5:0]  in;
    logic [7:0]  awaddr;
    logic [7:0]  araddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  status;
    logic [31:0] bus_rdata;
    logic [5:0]  exp_ctl;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic        chk_bus;
    logic [1:0]  exp_access;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(string name, logic [5:0] in, logic [7:0] aa, logic [7:0] ra,
                             logic [31:0] wd, logic [3:0] ws, logic [1:0] st, logic [31:0] brd,
                             logic [5:0] ec, logic [1:0] er, logic [31:0] ed);
    vec_t t;
    t.name = name; t.in = in; t.awaddr = aa; t.araddr = ra; t.wdata = wd; t.wstrb = ws;
    t.status = st; t.bus_rdata = brd; t.exp_ctl = ec; t.exp_resp = er; t.exp_rdata = ed;
    t.chk_bus = 1'b0; t.exp_access = 2'b00; t.exp_addr = '0; t.exp_wdata = '0; t.exp_strb = '0;
    return t;
  endfunction

  function automatic vec_t with_bus(vec_t t, logic [1:0] acc, logic [7:0] a,
                                    logic [31:0] wd, logic [3:0] s);
    vec_t r = t;
    r.chk_bus = 1'b1; r.exp_access = acc; r.exp_addr = a; r.exp_wdata = wd; r.exp_strb = s;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive, let combinational outputs settle, compare, advance.
  task automatic apply(vec_t t);
    {awvalid, wvalid, arvalid, bready, rready, bus_if.ready} = t.in;
    awaddr = t.awaddr; araddr = t.araddr; wdata = t.wdata; wstrb = t.wstrb;
    bus_if.status = rggen_status'(t.status);
    bus_if.read_data = t.bus_rdata;
    #1;
    check({t.name, "/ctl"}, 64'({awready, wready, arready, bus_if.valid, bvalid, rvalid}),
          64'(t.exp_ctl));
    check({t.name, "/resp"}, 64'({bresp, rresp}), 64'({t.exp_resp, t.exp_resp}));
    check({t.name, "/rdata"}, 64'(rdata), 64'(t.exp_rdata));
    if (t.chk_bus) begin
      check({t.name, "/bus"},
            {14'(bus_if.access), bus_if.address, bus_if.write_data, 4'(bus_if.strobe)},
            {14'(t.exp_access), t.exp_addr, t.exp_wdata, t.exp_strb});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {awvalid, wvalid, arvalid, bready, rready, bus_if.ready} = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [1:0] W = 2'b11;
  localparam logic [1:0] R = 2'b10;

  initial begin
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    bus_if.status = RGGEN_OKAY; bus_if.read_data = '0;

    // Write 0x10 (ready on 2nd request cycle), read 0x20 SLAVE_ERROR,
    // write with DECODE_ERROR and stalled bready while AR waits, then a read.
    tbl.push_back(v("reset_state", 6'b000000, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_IDLE, 2'b00, 32'h0));
    tbl.push_back(v("wr_grant",    6'b110000, 8'h10, 8'h00, 32'h12345678, 4'hF, 2'b00, 32'h0, C_WGNT, 2'b00, 32'h0));
    tbl.push_back(with_bus(v("wr_req0", 6'b000000, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_REQ, 2'b00, 32'h0),
                           W, 8'h10, 32'h12345678, 4'hF));
    tbl.push_back(with_bus(v("wr_req1", 6'b000001, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_REQ, 2'b00, 32'h0),
                           W, 8'h10, 32'h12345678, 4'hF));
    tbl.push_back(v("wr_b_okay",   6'b000100, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_B, 2'b00, 32'h0));
    tbl.push_back(v("rd_grant",    6'b001000, 8'h00, 8'h20, 32'h0, 4'h0, 2'b00, 32'h0, C_RGNT, 2'b00, 32'h0));
    tbl.push_back(with_bus(v("rd_req", 6'b000001, 8'h00, 8'h00, 32'h0, 4'h0, 2'b10, 32'hCAFEF00D, C_REQ, 2'b00, 32'h0),
                           R, 8'h20, 32'h0, 4'hF));
    tbl.push_back(v("rd_r_stall",  6'b000000, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'hFFFFFFFF, C_R, 2'b10, 32'hCAFEF00D));
    tbl.push_back(v("rd_r_done",   6'b000010, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_R, 2'b10, 32'hCAFEF00D));
    tbl.push_back(v("wr2_grant",   6'b110000, 8'h44, 8'h00, 32'hA5A55A5A, 4'h3, 2'b00, 32'h0, C_WGNT, 2'b10, 32'hCAFEF00D));
    tbl.push_back(with_bus(v("wr2_req", 6'b000001, 8'h00, 8'h00, 32'h0, 4'h0, 2'b11, 32'h55555555, C_REQ, 2'b10, 32'hCAFEF00D),
                           W, 8'h44, 32'hA5A55A5A, 4'h3));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(v($sformatf("wr2_b_stall%0d", i), 6'b001000, 8'h00, 8'h08, 32'h0, 4'h0, 2'b00, 32'h0,
                      C_B, 2'b11, 32'hCAFEF00D));
    end
    tbl.push_back(v("wr2_b_done",  6'b001100, 8'h00, 8'h08, 32'h0, 4'h0, 2'b00, 32'h0, C_B, 2'b11, 32'hCAFEF00D));
    tbl.push_back(v("rd2_grant",   6'b001000, 8'h00, 8'h08, 32'h0, 4'h0, 2'b00, 32'h0, C_RGNT, 2'b11, 32'hCAFEF00D));
    tbl.push_back(with_bus(v("rd2_req", 6'b000001, 8'h00, 8'h00, 32'h0, 4'h0, 2'b01, 32'h11112222, C_REQ, 2'b11, 32'hCAFEF00D),
                           R, 8'h08, 32'h0, 4'hF));
    tbl.push_back(v("rd2_r_done",  6'b000010, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_R, 2'b01, 32'h11112222));
    tbl.push_back(v("idle_again",  6'b000000, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_IDLE, 2'b01, 32'h11112222));

    do_reset();
    foreach (tbl[i]) apply(tbl[i]);

    // All of AW, W, AR held from reset: write, read, write.
    begin
      logic [5:0] exp_seq [7];
      exp_seq = '{C_WGNT, C_REQ, C_B, C_RGNT, C_REQ, C_R, C_WGNT};
      do_reset();
      for (int i = 0; i < 7; i++) begin
        apply(v($sformatf("rr_cycle%0d", i), 6'b111111, 8'h30, 8'h34, 32'h0BAD0BAD, 4'hF, 2'b00, 32'h0,
                exp_seq[i], 2'b00, 32'h0));
      end
    end

    // AW without W: read goes first, write waits until W arrives.
    begin
      logic [5:0] exp_seq [6];
      logic [5:0] in_seq  [6];
      exp_seq = '{C_RGNT, C_REQ, C_R, C_IDLE, C_IDLE, C_WGNT};
      in_seq  = '{6'b101001, 6'b100001, 6'b100011, 6'b100000, 6'b100000, 6'b110000};
      do_reset();
      for (int i = 0; i < 6; i++) begin
        apply(v($sformatf("aw_only%0d", i), in_seq[i], 8'h50, 8'h54, 32'h0, 4'hF, 2'b00, 32'h87654321,
                exp_seq[i], 2'b00, (i >= 2) ? 32'h87654321 : 32'h0));
      end
    end

    // Reset in REQUEST: no response, then a clean read.
    do_reset();
    apply(v("rst_wr_grant", 6'b110000, 8'h60, 8'h00, 32'h0F0F0F0F, 4'hF, 2'b00, 32'h0, C_WGNT, 2'b00, 32'h0));
    apply(v("rst_wr_req",   6'b000000, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_REQ, 2'b00, 32'h0));
    rst = 1'b1;
    apply(v("rst_in_req",   6'b000111, 8'h00, 8'h00, 32'h0, 4'h0, 2'b11, 32'h0, C_REQ, 2'b00, 32'h0));
    rst = 1'b0;
    apply(v("rst_after0",   6'b000110, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_IDLE, 2'b00, 32'h0));
    apply(v("rst_after1",   6'b000110, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_IDLE, 2'b00, 32'h0));
    apply(v("post_rd_grant", 6'b001000, 8'h00, 8'h64, 32'h0, 4'h0, 2'b00, 32'h0, C_RGNT, 2'b00, 32'h0));
    apply(with_bus(v("post_rd_req", 6'b000001, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, C_REQ, 2'b00, 32'h0),
                   R, 8'h64, 32'h0, 4'hF));
    apply(v("post_rd_r",    6'b000010, 8'h00, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, C_R, 2'b00, 32'hDEADBEEF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
